// File: rtl/adder_arb.sv
// Round-robin front end for a shared 2-input adder.
// In-order tag FIFO routes each result back to its requester.
module adder_arb #(
  parameter int BITS    = 17,
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*BITS-1:0] req_a,
  input  logic [NUM_REQ*BITS-1:0] req_b,
  output logic                    add_valid,
  output logic [BITS-1:0]         add_a,
  output logic [BITS-1:0]         add_b,
  input  logic                    add_valid_out,
  input  logic [BITS-1:0]         add_o,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [BITS-1:0]         rsp_data,
  output logic                    err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_OUT);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUT - 1);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand;
  logic          grant_ok;

  logic [IW-1:0] tag_mem [MAX_OUT];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Search for the first valid requester after the last grant
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_ok && req_valid[cand]) begin
        grant_ok  = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant only when a tag slot is free; a same-cycle pop does not count
  always_comb begin
    req_ready = '0;
    if (!rst && grant_ok && count != FULL)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  // Handshake and result routing
  always_comb begin
    push      = |(req_valid & req_ready);
    pop       = !rst && add_valid_out && (count != '0);
    rsp_valid = '0;
    if (pop)
      rsp_valid = NUM_REQ'(1) << tag_mem[rd_ptr];
    rsp_data  = add_o;
  end

  // Issue register toward the adder and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      add_valid  <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else begin
      add_valid <= push;
      if (push) begin
        add_a      <= req_a[grant_idx*BITS +: BITS];
        add_b      <= req_b[grant_idx*BITS +: BITS];
        last_grant <= grant_idx;
      end
    end
  end

  // Tag storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= grant_idx;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a result with no owner
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (add_valid_out && count == '0)
      err <= 1'b1;
  end

endmodule

// File: tb/tb_adder_arb.sv
// Directed bench for adder_arb.
// Adder results are driven by hand with precomputed sums.
module tb_adder_arb;

  localparam int BITS = 17;
  localparam int N    = 4;
  localparam int M    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*BITS-1:0] req_a = '0;
  logic [N*BITS-1:0] req_b = '0;
  logic              add_valid;
  logic [BITS-1:0]   add_a;
  logic [BITS-1:0]   add_b;
  logic              add_valid_out = 1'b0;
  logic [BITS-1:0]   add_o = '0;
  logic [N-1:0]      rsp_valid;
  logic [BITS-1:0]   rsp_data;
  logic              err;

  int nvec = 0;
  int nmis = 0;

  adder_arb #(.BITS(BITS), .NUM_REQ(N), .MAX_OUT(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .add_valid    (add_valid),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_valid_out(add_valid_out),
    .add_o        (add_o),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops;
    for (int i = 0; i < N; i++) begin
      req_a[i*BITS +: BITS] = BITS'(10*i + 1);
      req_b[i*BITS +: BITS] = BITS'(100 + i);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    add_valid_out = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // reset values, outputs forced quiet even with stimulus present
    load_ops();
    req_valid = 4'hF;
    add_valid_out = 1'b1;
    add_o = 17'h3;
    step();
    step();
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_add_valid", 32'(add_valid), 32'h0);
    chk("rst_add_a", 32'(add_a), 32'h0);
    chk("rst_add_b", 32'(add_b), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h3);

    // single request 5 + 7
    rst = 1'b0;
    add_valid_out = 1'b0;
    req_a[0 +: BITS] = 17'd5;
    req_b[0 +: BITS] = 17'd7;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("single_add_valid", 32'(add_valid), 32'h1);
    chk("single_add_a", 32'(add_a), 32'd5);
    chk("single_add_b", 32'(add_b), 32'd7);
    step();
    chk("idle_add_valid", 32'(add_valid), 32'h0);
    chk("hold_add_a", 32'(add_a), 32'd5);
    add_valid_out = 1'b1;
    add_o = 17'd12;
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", 32'(rsp_data), 32'd12);
    step();
    add_valid_out = 1'b0;
    chk("single_err", 32'(err), 32'h0);

    // all four requesting: grants 0,1,2,3 then full
    do_reset();
    load_ops();
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << k));
      step();
      chk($sformatf("rr_add_a%0d", k), 32'(add_a), 32'(10*k + 1));
      chk($sformatf("rr_add_b%0d", k), 32'(add_b), 32'(100 + k));
    end
    #1;
    chk("full_ready", 32'(req_ready), 32'h0);
    step();
    chk("full_add_valid", 32'(add_valid), 32'h0);

    // pop while full: no pass-through, accept next cycle
    add_valid_out = 1'b1;
    add_o = 17'h1FFFF;
    #1;
    chk("pop_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("pop_rsp_data", 32'(rsp_data), 32'h1FFFF);
    chk("pop_ready", 32'(req_ready), 32'h0);
    step();
    add_valid_out = 1'b0;
    #1;
    chk("after_pop_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("after_pop_add_a", 32'(add_a), 32'd1);

    // drain: tags 1,2,3,0 in issue order
    for (int k = 0; k < 4; k++) begin
      add_valid_out = 1'b1;
      add_o = BITS'(50 + k);
      #1;
      chk($sformatf("drain_rsp%0d", k), 32'(rsp_valid),
          32'(1 << ((k + 1) % 4)));
      chk($sformatf("drain_data%0d", k), 32'(rsp_data), 32'(50 + k));
      step();
    end
    add_valid_out = 1'b0;

    // spurious result with empty FIFO
    add_valid_out = 1'b1;
    add_o = 17'd9;
    #1;
    chk("spur_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("spur_err_pre", 32'(err), 32'h0);
    step();
    add_valid_out = 1'b0;
    chk("spur_err_set", 32'(err), 32'h1);
    step();
    chk("spur_err_hold", 32'(err), 32'h1);

    // reset with three tags in flight (last grant 0 -> 1,2,3)
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("pre_rst_ready%0d", k), 32'(req_ready),
          32'(1 << (k + 1)));
      step();
    end
    rst = 1'b1;
    add_valid_out = 1'b1;
    #1;
    chk("in_rst_ready", 32'(req_ready), 32'h0);
    chk("in_rst_rsp", 32'(rsp_valid), 32'h0);
    step();
    add_valid_out = 1'b0;
    chk("in_rst_add_valid", 32'(add_valid), 32'h0);
    chk("in_rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();
    add_valid_out = 1'b1;
    #1;
    chk("post_rst_rsp", 32'(rsp_valid), 32'h0);
    step();
    add_valid_out = 1'b0;
    chk("post_rst_err", 32'(err), 32'h1);

    // requester 2 alone, then 1 and 3 together
    do_reset();
    load_ops();
    req_valid = 4'b0100;
    #1;
    chk("r2_ready", 32'(req_ready), 32'h4);
    step();
    chk("r2_add_a", 32'(add_a), 32'd21);
    req_valid = 4'b1010;
    #1;
    chk("r13_ready", 32'(req_ready), 32'h8);
    step();
    chk("r3_add_a", 32'(add_a), 32'd31);
    req_valid = 4'b0010;
    #1;
    chk("r1_ready", 32'(req_ready), 32'h2);
    step();
    chk("r1_add_a", 32'(add_a), 32'd11);
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
